// File: rtl/tx_serial.sv
// UART-style serial transmitter: start bit, N_BITS data LSB first, parity, stop bit(s).
// Latency: start bit on txd the cycle after the accepting edge; frame = (N_BITS+2+STOP_BITS)*CLK_P_BIT cycles + 1 FIM cycle.
// Backpressure: partida is only sampled in IDLE/FIM; requests while busy are dropped, never queued.
module tx_serial #(
  parameter int BAUD_RATE = 9600,
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int N_BITS    = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] data,
  output logic              txd,
  output logic              ocupado,
  output logic              fim
);

  // Bit period in clock cycles, truncated toward zero.
  localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
  // Widths guarded so degenerate parameters (period or word of 1) still elaborate.
  localparam int CNT_W  = (CLK_P_BIT > 1) ? $clog2(CLK_P_BIT) : 1;
  localparam int IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_P_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    FIM   = 3'd5
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [STOP_W-1:0]   stop_idx;
  logic [N_BITS-1:0]   shift_reg;
  logic                par_bit;

  logic [N_BITS-1:0]   shift_next;
  logic                bit_end;
  logic                data_par;

  // Word as it will look after the next shift; its LSB is the next data bit on the line.
  assign shift_next = shift_reg >> 1;
  // Last cycle of the current bit period.
  assign bit_end    = (bit_cnt == CNT_LAST);
  // Parity of the incoming word, taken on the accepting edge so later data changes cannot leak in.
  assign data_par   = (PARITY != 0) ? ~^data : ^data;

  // Frame sequencer; txd/ocupado/fim are loaded with the value the next state implies,
  // so they are registered and have no combinational path from the inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      txd       <= 1'b1;
      ocupado   <= 1'b0;
      fim       <= 1'b0;
    end else begin
      case (state)
        // IDLE and FIM accept identically, which is what allows back-to-back frames.
        IDLE, FIM: begin
          fim     <= 1'b0;
          bit_cnt <= '0;
          bit_idx <= '0;
          stop_idx <= '0;
          if (partida) begin
            shift_reg <= data;
            par_bit   <= data_par;
            state     <= START;
            txd       <= 1'b0;
            ocupado   <= 1'b1;
          end else begin
            state   <= IDLE;
            txd     <= 1'b1;
            ocupado <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= PAR;
              txd   <= par_bit;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_next;
              txd       <= shift_next[0];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        PAR: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            stop_idx <= '0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // Stop bits are counted as whole bit periods so each one is exactly CLK_P_BIT long.
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              state   <= FIM;
              fim     <= 1'b1;
              ocupado <= 1'b0;
              txd     <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          txd     <= 1'b1;
          ocupado <= 1'b0;
          fim     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serial.sv
// Bench for tx_serial: two instances (odd and even parity) at a 10-cycle bit period.
// Expected frames are queued when a request is driven and popped when the line starts the frame.
// Every cycle of each frame is compared for txd, ocupado and fim.
module tb_tx_serial;

  localparam int P  = 10;
  localparam int NB = 8;
  localparam int SB = 1;
  localparam int F  = (NB + 2 + SB) * P;

  logic       clock = 1'b0;
  logic [1:0] reset;
  logic [1:0] partida;
  logic [7:0] data [2];
  wire  [1:0] txd;
  wire  [1:0] ocupado;
  wire  [1:0] fim;

  int vectors     = 0;
  int miscompares = 0;
  logic [10:0] sb_q [$];

  always #5 clock = ~clock;

  tx_serial #(.BAUD_RATE(100), .CLOCK_HZ(1000), .N_BITS(NB), .PARITY(1), .STOP_BITS(SB)) u_odd (
    .clock(clock), .reset(reset[0]), .partida(partida[0]), .data(data[0]),
    .txd(txd[0]), .ocupado(ocupado[0]), .fim(fim[0])
  );

  tx_serial #(.BAUD_RATE(100), .CLOCK_HZ(1000), .N_BITS(NB), .PARITY(0), .STOP_BITS(SB)) u_even (
    .clock(clock), .reset(reset[1]), .partida(partida[1]), .data(data[1]),
    .txd(txd[1]), .ocupado(ocupado[1]), .fim(fim[1])
  );

  // Frame bits in line order (bit 0 first): start, data LSB first, parity, stop.
  function automatic logic [10:0] frame_of(input int sel, input logic [7:0] w);
    logic p;
    p = (sel == 0) ? ~^w : ^w;
    return {1'b1, p, w, 1'b0};
  endfunction

  // Sends word w on instance sel and checks every cycle up to FIM (plus one idle cycle).
  // pre: partida was already raised in the previous FIM cycle. next_w >= 0 raises it again in FIM.
  // busy_at: cycle of the frame in which a stray request is pulsed. abort_at: cycle to pull reset.
  task automatic run_frame(input int sel, input logic [7:0] w, input bit pre,
                           input int next_w, input int busy_at, input int abort_at);
    logic [10:0] exp_f;
    logic [10:0] got_f;
    logic        et, eo, ef;
    int          b;
    int          last;
    exp_f = '0;
    got_f = '0;
    if (!pre) begin
      partida[sel] = 1'b1;
      data[sel]    = w;
    end
    sb_q.push_back(frame_of(sel, w));
    @(posedge clock);
    @(negedge clock);
    partida[sel] = 1'b0;
    data[sel]    = ~w;
    last = (next_w >= 0) ? F + 1 : F + 2;
    for (int j = 1; j <= last; j++) begin
      if (j > 1) @(negedge clock);
      if (j == 1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty sel=%0d got=0 entries required>=1", sel);
        end else begin
          exp_f = sb_q.pop_front();
        end
      end
      if (abort_at > 0 && j > abort_at) begin
        vectors++;
        if (txd[sel] !== 1'b1 || ocupado[sel] !== 1'b0 || fim[sel] !== 1'b0) begin
          miscompares++;
          $display("FAIL after_abort sel=%0d j=%0d got txd/ocu/fim=%b%b%b required 100",
                   sel, j, txd[sel], ocupado[sel], fim[sel]);
        end
        if (j == abort_at + 3) reset[sel] = 1'b1;
      end else begin
        if (j <= F) begin
          b  = (j - 1) / P;
          et = exp_f[b];
          eo = 1'b1;
          ef = 1'b0;
          if ((j - 1) % P == P / 2) got_f[b] = txd[sel];
        end else if (j == F + 1) begin
          et = 1'b1; eo = 1'b0; ef = 1'b1;
        end else begin
          et = 1'b1; eo = 1'b0; ef = 1'b0;
        end
        vectors++;
        if (txd[sel] !== et) begin
          miscompares++;
          $display("FAIL txd sel=%0d word=%h j=%0d got=%b required=%b", sel, w, j, txd[sel], et);
        end
        vectors++;
        if (ocupado[sel] !== eo) begin
          miscompares++;
          $display("FAIL ocupado sel=%0d word=%h j=%0d got=%b required=%b", sel, w, j, ocupado[sel], eo);
        end
        vectors++;
        if (fim[sel] !== ef) begin
          miscompares++;
          $display("FAIL fim sel=%0d word=%h j=%0d got=%b required=%b", sel, w, j, fim[sel], ef);
        end
      end
      if (j == abort_at) begin
        reset[sel] = 1'b0;
        #1;
        vectors++;
        if (txd[sel] !== 1'b1 || ocupado[sel] !== 1'b0 || fim[sel] !== 1'b0) begin
          miscompares++;
          $display("FAIL async_reset sel=%0d got txd/ocu/fim=%b%b%b required 100",
                   sel, txd[sel], ocupado[sel], fim[sel]);
        end
      end
      if (j == busy_at) begin
        partida[sel] = 1'b1;
        data[sel]    = 8'hAA;
      end
      if (busy_at > 0 && j == busy_at + 1) partida[sel] = 1'b0;
      if (j == F + 1 && next_w >= 0) begin
        partida[sel] = 1'b1;
        data[sel]    = next_w[7:0];
      end
    end
    if (abort_at == 0) begin
      vectors++;
      if (got_f !== exp_f) begin
        miscompares++;
        $display("FAIL midpoint_decode sel=%0d got=%b required=%b", sel, got_f, exp_f);
      end
    end
  endtask

  task automatic test_reset;
    reset   = 2'b11;
    partida = 2'b00;
    data[0] = 8'h00;
    data[1] = 8'h00;
    #2 reset = 2'b00;
    for (int c = 0; c < 23; c++) begin
      @(negedge clock);
      if (c == 3) reset = 2'b11;
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (txd[s] !== 1'b1 || ocupado[s] !== 1'b0 || fim[s] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_idle sel=%0d c=%0d got txd/ocu/fim=%b%b%b required 100",
                   s, c, txd[s], ocupado[s], fim[s]);
        end
      end
    end
  endtask

  task automatic test_odd_frame;
    run_frame(0, 8'h56, 1'b0, -1, 0, 0);
  endtask

  task automatic test_even_parity;
    run_frame(1, 8'h7B, 1'b0, -1, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_frame(0, 8'h55, 1'b0, 8'hC3, 25, 0);
    run_frame(0, 8'hC3, 1'b1, -1, 0, 0);
  endtask

  task automatic test_midframe_reset;
    run_frame(0, 8'h3C, 1'b0, -1, 0, 35);
    run_frame(0, 8'h0F, 1'b0, -1, 0, 0);
  endtask

  task automatic test_word_patterns;
    logic [7:0] words [4];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h56;
    words[3] = 8'h7B;
    for (int i = 0; i < 4; i++) begin
      run_frame(0, words[i], 1'b0, -1, 0, 0);
      run_frame(1, words[i], 1'b0, -1, 0, 0);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_odd_frame();
    test_even_parity();
    test_back_to_back();
    test_midframe_reset();
    test_word_patterns();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
